regfile_wb: RTL and testbench

REGFILE_WB -- requirements
Module: regfile_wb

---
 rtl/regfile_wb_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 54 +++++
 rtl/regfile_wb.sv | 78 +++++++
 tb/tb_regfile_wb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared widths and writeback-select encodings for the register file slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
package regfile_wb_pkg;
    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard with read-side pending detection and orphan-writeback flag.
// Latency: set/clear take effect at the next edge; pend/stall combinational; orphan registered 1 cycle.
// Backpressure: none; stall is advisory to the issue stage.
module regfile_scoreboard #(
    parameter int NREG = regfile_wb_pkg::NREG
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wb_vld,
    input  logic [regfile_wb_pkg::REG_IDX_W-1:0] wb_rd,
    input  logic                              iss_vld,
    input  logic [regfile_wb_pkg::REG_IDX_W-1:0] iss_rd,
    input  logic [regfile_wb_pkg::REG_IDX_W-1:0] rs1,
    input  logic [regfile_wb_pkg::REG_IDX_W-1:0] rs2,
    output logic                              stall,
    output logic                              wb_orphan
);
    import regfile_wb_pkg::*;

    logic [NREG-1:0] busy_q, busy_d;
    logic            orphan_q, orphan_d;
    logic            pend1, pend2;

    // Set is applied after clear so a same-cycle reissue keeps the register owned.
    always_comb begin
        busy_d = busy_q;
        if (wb_vld) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (iss_vld) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
        orphan_d  = wb_vld && !busy_q[wb_rd];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            orphan_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            orphan_q <= orphan_d;
        end
    end

    always_comb begin
        pend1 = busy_q[rs1] && !(wb_vld && (wb_rd == rs1));
        pend2 = busy_q[rs2] && !(wb_vld && (wb_rd == rs2));
    end

    assign stall     = pend1 || pend2;
    assign wb_orphan = orphan_q;
endmodule

// File: rtl/regfile_wb.sv
// Architectural register file with writeback mux, same-cycle bypass and busy scoreboard.
// Latency: reads/bypass combinational; writes land at the next rising edge.
// Backpressure: none; stall flags a pending source operand, r0 hardwired to zero.
module regfile_wb #(
    parameter int XLEN = regfile_wb_pkg::XLEN,
    parameter int NREG = regfile_wb_pkg::NREG
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wb_valid,
    input  logic [regfile_wb_pkg::REG_IDX_W-1:0] wb_rd,
    input  logic                                 wb_sel,
    input  logic [XLEN-1:0]                      wb_alu,
    input  logic [XLEN-1:0]                      wb_mem,
    input  logic                                 iss_valid,
    input  logic [regfile_wb_pkg::REG_IDX_W-1:0] iss_rd,
    input  logic [regfile_wb_pkg::REG_IDX_W-1:0] rs1,
    input  logic [regfile_wb_pkg::REG_IDX_W-1:0] rs2,
    output logic [XLEN-1:0]                      rd1,
    output logic [XLEN-1:0]                      rd2,
    output logic                                 stall,
    output logic                                 wb_orphan
);
    import regfile_wb_pkg::*;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [XLEN-1:0] wd;
    logic            wb_fire;
    logic            iss_fire;

    // Gating with rst_n discards anything presented while reset is held.
    assign wb_fire  = rst_n && wb_valid  && (wb_rd  != '0);
    assign iss_fire = rst_n && iss_valid && (iss_rd != '0);
    assign wd       = (wb_sel == WB_SEL_MEM) ? wb_mem : wb_alu;

    always_comb begin
        regs_d = regs_q;
        if (wb_fire) begin
            regs_d[wb_rd] = wd;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rst_n) begin
            rd1 = (wb_fire && (wb_rd == rs1)) ? wd : regs_q[rs1];
            rd2 = (wb_fire && (wb_rd == rs2)) ? wd : regs_q[rs2];
        end
    end

    regfile_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_vld    (wb_fire),
        .wb_rd     (wb_rd),
        .iss_vld   (iss_fire),
        .iss_rd    (iss_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .stall     (stall),
        .wb_orphan (wb_orphan)
    );
endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: stimulus queues expected read/stall/orphan values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_wb;
    localparam logic [3:0] M_RD1 = 4'b0001;
    localparam logic [3:0] M_RD2 = 4'b0010;
    localparam logic [3:0] M_STL = 4'b0100;
    localparam logic [3:0] M_ORP = 4'b1000;
    localparam logic [3:0] M_ALL = 4'b1111;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        stall;
        logic        orph;
        logic [3:0]  mask;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_sel;
    logic [31:0] wb_alu;
    logic [31:0] wb_mem;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        stall;
    logic        wb_orphan;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    regfile_wb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_sel    (wb_sel),
        .wb_alu    (wb_alu),
        .wb_mem    (wb_mem),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd1       (rd1),
        .rd2       (rd2),
        .stall     (stall),
        .wb_orphan (wb_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] a, input logic [4:0] b);
        wb_valid  = 1'b0;
        wb_rd     = '0;
        wb_sel    = 1'b0;
        wb_alu    = '0;
        wb_mem    = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        rs1       = a;
        rs2       = b;
    endtask

    task automatic wb(input logic [4:0] rd, input logic sel,
                      input logic [31:0] alu, input logic [31:0] mem);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_sel   = sel;
        wb_alu   = alu;
        wb_mem   = mem;
    endtask

    task automatic iss(input logic [4:0] rd);
        iss_valid = 1'b1;
        iss_rd    = rd;
    endtask

    task automatic expect_out(input string nm, input logic [3:0] m,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic es, input logic eo);
        exp_t e;
        e.rd1   = e1;
        e.rd2   = e2;
        e.stall = es;
        e.orph  = eo;
        e.mask  = m;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: everything queued during a cycle is checked at the following negedge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.mask[0]) begin
                    n_vec++;
                    if (rd1 !== e.rd1) begin
                        n_err++;
                        $display("FAIL %s.rd1: got %h want %h", nm, rd1, e.rd1);
                    end
                end
                if (e.mask[1]) begin
                    n_vec++;
                    if (rd2 !== e.rd2) begin
                        n_err++;
                        $display("FAIL %s.rd2: got %h want %h", nm, rd2, e.rd2);
                    end
                end
                if (e.mask[2]) begin
                    n_vec++;
                    if (stall !== e.stall) begin
                        n_err++;
                        $display("FAIL %s.stall: got %b want %b", nm, stall, e.stall);
                    end
                end
                if (e.mask[3]) begin
                    n_vec++;
                    if (wb_orphan !== e.orph) begin
                        n_err++;
                        $display("FAIL %s.orphan: got %b want %b", nm, wb_orphan, e.orph);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        idle(5'd0, 5'd0);
        step();
        expect_out("reset_idle", M_ALL, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        // Writeback and issue presented under reset must be discarded.
        idle(5'd5, 5'd6);
        wb(5'd5, 1'b0, 32'hAAAA_AAAA, 32'h0);
        iss(5'd6);
        expect_out("reset_wb_gated", M_ALL, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        idle(5'd5, 5'd6);
        expect_out("reset_discard", M_ALL, 32'h0, 32'h0, 1'b0, 1'b0);

        // Basic ALU writeback with bypass, then registered read.
        step();
        idle(5'd5, 5'd0);
        wb(5'd5, 1'b0, 32'h0000_1234, 32'hBAD0_BAD0);
        expect_out("wb5_bypass", M_RD1 | M_ORP, 32'h0000_1234, 32'h0, 1'b0, 1'b0);
        step();
        idle(5'd5, 5'd0);
        expect_out("wb5_read", M_ALL, 32'h0000_1234, 32'h0, 1'b0, 1'b1);

        // Writes to r0 are ignored and never flag orphan.
        step();
        idle(5'd0, 5'd5);
        wb(5'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expect_out("r0_bypass", M_RD1 | M_RD2 | M_ORP, 32'h0, 32'h0000_1234, 1'b0, 1'b0);
        step();
        idle(5'd0, 5'd0);
        expect_out("r0_read", M_RD1 | M_ORP, 32'h0, 32'h0, 1'b0, 1'b0);

        // Issue r7, stall on it, then a memory writeback releases it.
        step();
        idle(5'd0, 5'd7);
        iss(5'd7);
        expect_out("iss7_same", M_STL, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        idle(5'd0, 5'd7);
        expect_out("iss7_stall", M_RD2 | M_STL, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        idle(5'd0, 5'd7);
        wb(5'd7, 1'b1, 32'h1111_1111, 32'hDEAD_BEEF);
        expect_out("wb7_mem_bypass", M_ALL, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step();
        idle(5'd0, 5'd7);
        expect_out("wb7_cleared", M_ALL, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Same-cycle set and clear of r3: set wins, and it was an orphan write.
        step();
        idle(5'd3, 5'd0);
        iss(5'd3);
        wb(5'd3, 1'b0, 32'h0000_0033, 32'h0);
        expect_out("setclr3_same", M_RD1 | M_STL, 32'h0000_0033, 32'h0, 1'b0, 1'b0);
        step();
        idle(5'd3, 5'd0);
        expect_out("setclr3_after", M_ALL, 32'h0000_0033, 32'h0, 1'b1, 1'b1);
        step();
        idle(5'd3, 5'd0);
        wb(5'd3, 1'b0, 32'h0000_0034, 32'h0);
        expect_out("wb3_release", M_RD1 | M_STL | M_ORP, 32'h0000_0034, 32'h0, 1'b0, 1'b0);
        step();
        idle(5'd3, 5'd0);
        expect_out("wb3_no_orphan", M_ALL, 32'h0000_0034, 32'h0, 1'b0, 1'b0);

        // Orphan writeback to r9 pulses wb_orphan for exactly one cycle.
        step();
        idle(5'd0, 5'd0);
        wb(5'd9, 1'b0, 32'h0000_0099, 32'h0);
        step();
        idle(5'd9, 5'd0);
        expect_out("orphan9_pulse", M_RD1 | M_ORP, 32'h0000_0099, 32'h0, 1'b0, 1'b1);
        step();
        idle(5'd9, 5'd0);
        expect_out("orphan9_drop", M_RD1 | M_ORP, 32'h0000_0099, 32'h0, 1'b0, 1'b0);

        // Double issue of r12 does not count: one writeback clears it.
        step();
        idle(5'd0, 5'd0);
        iss(5'd12);
        step();
        idle(5'd0, 5'd12);
        iss(5'd12);
        expect_out("iss12_twice", M_STL, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        idle(5'd0, 5'd0);
        wb(5'd12, 1'b0, 32'h0000_000C, 32'h0);
        step();
        idle(5'd12, 5'd0);
        expect_out("wb12_single_clear", M_ALL, 32'h0000_000C, 32'h0, 1'b0, 1'b0);

        // Busy r4 holding 0x55 and busy r20, then reset asserted mid-cycle.
        step();
        idle(5'd0, 5'd0);
        iss(5'd4);
        iss_valid = 1'b1;
        step();
        idle(5'd0, 5'd0);
        iss(5'd4);
        wb(5'd4, 1'b0, 32'h0000_0055, 32'h0);
        step();
        idle(5'd0, 5'd0);
        iss(5'd20);
        step();
        idle(5'd4, 5'd20);
        expect_out("pre_reset", M_ALL, 32'h0000_0055, 32'h0, 1'b1, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        expect_out("mid_reset", M_ALL, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        idle(5'd4, 5'd20);
        expect_out("post_reset", M_ALL, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        idle(5'd0, 5'd0);
        wb(5'd4, 1'b0, 32'h0000_0077, 32'h0);
        step();
        idle(5'd4, 5'd0);
        expect_out("post_reset_orphan", M_ALL, 32'h0000_0077, 32'h0, 1'b0, 1'b1);

        step();
        idle(5'd0, 5'd0);
        step();
        step();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: pending=%0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
